// File: rtl/dmem_responder.sv
// dmem_responder: word memory behind the load/store unit with lane shift, error checks and wait states
module dmem_responder #(
  parameter int ADDR_W = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strobe,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] strobe_q;
  logic [31:0] mem [2**ADDR_W];
  logic in_idle, accept, access, we_s, oor, bad, err;
  logic [31:0] addr_s, wdata_s, sh_wdata;
  logic [3:0] strobe_s, sh_strobe;
  logic [ADDR_W-1:0] idx;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  // With zero wait states the access happens on the accept edge, so decode from the live request in IDLE
  always_comb begin
    in_idle = state == IDLE;
    accept = req_valid & in_idle;
    we_s = in_idle ? req_we : we_q;
    addr_s = in_idle ? req_addr : addr_q;
    wdata_s = in_idle ? req_wdata : wdata_q;
    strobe_s = in_idle ? req_strobe : strobe_q;
    sh_strobe = strobe_s << addr_s[1:0];
    sh_wdata = wdata_s << {addr_s[1:0], 3'b000};
    idx = addr_s[ADDR_W+1:2];
    oor = (addr_s >> (ADDR_W + 2)) != 32'd0;
    bad = we_s & ((strobe_s != 4'b0001 && strobe_s != 4'b0011 && strobe_s != 4'b1111) ||
                  (strobe_s == 4'b0011 && addr_s[0]) ||
                  (strobe_s == 4'b1111 && addr_s[1:0] != 2'b00));
    err = oor | bad;
    state_n = in_idle ? (accept ? (WAIT_STATES > 0 ? WAIT : RESP) : IDLE) :
              state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) :
              (rsp_ready ? IDLE : RESP);
    access = state_n == RESP && state != RESP;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      we_q <= 1'b0;
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      strobe_q <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q <= req_we;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        strobe_q <= req_strobe;
        cnt <= 4'(WAIT_STATES - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rsp_err <= err;
        rsp_rdata <= (we_s | err) ? 32'd0 : mem[idx];
      end else if (rsp_valid & rsp_ready) begin
        rsp_err <= 1'b0;
        rsp_rdata <= 32'd0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && access && we_s && !err)
      for (int i = 0; i < 4; i++)
        if (sh_strobe[i]) mem[idx][8*i +: 8] <= sh_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench driving a zero-wait and a three-wait instance against a byte-level model
module tb_dmem_responder;
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic [1:0] rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0][3:0] req_strobe;
  int mode [2];
  int cyc = 0;
  int ntests = 0;
  int nfail = 0;
  exp_t sb [2][$];
  logic [7:0] mb [2][1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_responder #(.ADDR_W(8), .WAIT_STATES(g * 3)) u_dut (
      .clk(clk), .rst(rst[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_strobe(req_strobe[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
    );
  end

  task automatic check(string nm, int d, logic [31:0] got, logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, d, got, exp);
    end
  endtask

  // Reference: strobe gives an access size; a store must be size-aligned and in range
  task automatic model(int d, bit we, logic [31:0] a, logic [31:0] wd, logic [3:0] s,
                       output logic err, output logic [31:0] rd);
    int sz = (s == 4'd1) ? 1 : (s == 4'd3) ? 2 : (s == 4'd15) ? 4 : 0;
    err = a >= 32'd1024;
    if (we && (sz == 0 || a % sz != 0)) err = 1'b1;
    rd = 32'd0;
    if (!err) begin
      if (we) for (int i = 0; i < sz; i++) mb[d][int'(a) + i] = wd[8*i +: 8];
      else for (int i = 0; i < 4; i++) rd[8*i +: 8] = mb[d][(int'(a) & ~3) + i];
    end
  endtask

  task automatic issue(int d, bit we, logic [31:0] a, logic [31:0] wd, logic [3:0] s, bit upd);
    int n = 0;
    logic e;
    logic [31:0] r;
    while (!req_ready[d] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready[d]) begin
      ntests++;
      nfail++;
      $display("FAIL issue_timeout dut%0d: req_ready got 0 expected 1", d);
      return;
    end
    req_valid[d] = 1'b1;
    req_we[d] = we;
    req_addr[d] = a;
    req_wdata[d] = wd;
    req_strobe[d] = s;
    if (upd) begin
      model(d, we, a, wd, s, e, r);
      sb[d].push_back('{e, r, cyc + 1 + d * 3});
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  initial forever begin
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++)
      rsp_ready[d] = mode[d] == 0 ? 1'b1 : mode[d] == 2 ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic pv = 1'b0, pr = 1'b0, he = 1'b0;
    logic [31:0] hr = 32'd0;
    exp_t e;
    always @(negedge clk) begin
      if (rst[g]) begin
        pv = 1'b0;
        pr = 1'b0;
      end else begin
        if (pv && pr) begin
          check("post_hs_valid", g, 32'(rsp_valid[g]), 32'd0);
          check("post_hs_rdata", g, rsp_rdata[g], 32'd0);
        end
        if (rsp_valid[g]) begin
          if (sb[g].size() == 0) begin
            ntests++;
            nfail++;
            $display("FAIL spurious_rsp dut%0d: rsp_valid got 1 expected 0", g);
          end else begin
            if (!pv) check("latency", g, 32'(cyc), 32'(sb[g][0].due));
            else if (!pr) begin
              check("hold_rdata", g, rsp_rdata[g], hr);
              check("hold_err", g, 32'(rsp_err[g]), 32'(he));
              check("ready_low", g, 32'(req_ready[g]), 32'd0);
            end
            if (rsp_ready[g]) begin
              e = sb[g].pop_front();
              check("rdata", g, rsp_rdata[g], e.rdata);
              check("err", g, 32'(rsp_err[g]), 32'(e.err));
            end
          end
        end
        pv = rsp_valid[g];
        pr = rsp_ready[g];
        hr = rsp_rdata[g];
        he = rsp_err[g];
      end
    end
  end

  initial begin
    int n;
    logic [3:0] s;
    logic [31:0] a;
    rst = 2'b11;
    req_valid = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    req_strobe = '0;
    rsp_ready = '0;
    mode[0] = 0;
    mode[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", d, 32'(req_ready[d]), 32'd1);
      check("rst_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
      check("rst_rsp_err", d, 32'(rsp_err[d]), 32'd0);
      check("rst_rsp_rdata", d, rsp_rdata[d], 32'd0);
    end
    rst = 2'b00;
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++) issue(d, 1'b1, 32'(w * 4), $urandom, 4'hF, 1'b1);
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    issue(0, 1'b1, 32'h10, 32'h11223344, 4'hF, 1'b1);
    issue(0, 1'b1, 32'h13, 32'h000000AA, 4'h1, 1'b1);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    issue(0, 1'b1, 32'h20, 32'h0, 4'hF, 1'b1);
    issue(0, 1'b1, 32'h22, 32'h0000CAFE, 4'h3, 1'b1);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    issue(0, 1'b1, 32'h21, 32'h0000BEEF, 4'h3, 1'b1);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    issue(0, 1'b0, 32'h400, 32'h0, 4'h0, 1'b1);
    issue(0, 1'b1, 32'h24, 32'h12345678, 4'h5, 1'b1);
    issue(0, 1'b0, 32'h24, 32'h0, 4'h0, 1'b1);
    mode[1] = 2;
    issue(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    n = 0;
    while (!rsp_valid[1] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_rsp_seen", 1, 32'(rsp_valid[1]), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    mode[1] = 0;
    issue(1, 1'b1, 32'h14, 32'hA5A5A5A5, 4'hF, 1'b0);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    sb[1].delete();
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(negedge clk);
    check("rst_wait_valid", 1, 32'(rsp_valid[1]), 32'd0);
    check("rst_wait_ready", 1, 32'(req_ready[1]), 32'd1);
    @(posedge clk); #1;
    issue(1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b1);
    mode[0] = 1;
    mode[1] = 1;
    for (int k = 0; k < 300; k++) begin
      s = ($urandom_range(0, 7) == 0) ? 4'($urandom) : (($urandom_range(0, 2) == 0) ? 4'h1 :
          ($urandom_range(0, 1) == 0) ? 4'h3 : 4'hF);
      a = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h400) : 32'($urandom_range(0, 63));
      issue(k % 2, 1'($urandom), a, $urandom, s, 1'b1);
    end
    n = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_q0", 0, 32'(sb[0].size()), 32'd0);
    check("drain_q1", 1, 32'(sb[1].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
